acc_sequencer: RTL

Handshaked accumulator that sits directly upstream of the 32-bit ripple-carry adder with overflow detection. It sequences a burst of operands into the adder: feeds the running accumulator and each incoming operand (optionally inverted for subtraction) to the adder, then registers the sum, carry-out and overflow flag. After the last beat it presents one result on a valid/ready output port. It turns the combinational adder into a streaming multi-operand add/subtract unit.

---
 rtl/acc_sequencer_if.sv | 23 ++
 rtl/acc_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/acc_sequencer_if.sv
// Operand and result handshake bundle for acc_sequencer.
// The master modport is the producer/consumer side; the slave is the sequencer.
interface acc_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_of;

  modport master (
    output in_valid, in_data, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_of
  );

  modport slave (
    input  in_valid, in_data, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_of
  );
endinterface

// File: rtl/acc_sequencer.sv
// Streaming multi-operand add/subtract: accumulates a burst of operands through a
// 32-bit adder and presents the sum, last carry-out and sticky overflow.
//   state | meaning
//   IDLE  | waiting for start
//   ACC   | accepting operands, cnt beats remaining
//   DONE  | result held on the output port until taken
module acc_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  acc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_cout;
  logic             r_of;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [31:0] w_in2;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_of;
  logic        w_beat;

  // Subtraction is a + ~b + 1, so the carry-in doubles as the subtract flag.
  assign w_in2           = bus.in_sub ? ~bus.in_data : bus.in_data;
  assign {w_cout, w_sum} = {1'b0, r_acc} + {1'b0, w_in2} + {32'd0, bus.in_sub};
  assign w_of            = (r_acc[31] == w_in2[31]) & (w_sum[31] != r_acc[31]);
  assign w_beat          = bus.in_valid & r_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= 32'd0;
      r_cnt       <= '0;
      r_cout      <= 1'b0;
      r_of        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc  <= 32'd0;
            r_cnt  <= len;
            r_cout <= 1'b0;
            r_of   <= 1'b0;
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state    <= S_ACC;
              r_in_ready <= 1'b1;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_acc  <= w_sum;
            r_cout <= w_cout;
            r_of   <= r_of | w_of;
            r_cnt  <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_acc;
  assign bus.out_cout  = r_cout;
  assign bus.out_of    = r_of;
  assign busy          = r_busy;

endmodule
